// File: rtl/parc_bypass_scoreboard.sv
// Generic in-flight register-write tracker: bypass selects per decode read port plus the
// load-use / long-latency hazard stall. Entries advance through NUM_STAGES tracked stages.
module parc_byp_lookup #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int SEL_W      = 2
) (
  input  logic                                 rd_en,
  input  logic [REG_AW-1:0]                    rd_addr,
  input  logic [NUM_STAGES-1:0]                prod,
  input  logic [NUM_STAGES-1:0][REG_AW-1:0]    waddr,
  input  logic [NUM_STAGES-1:0][SEL_W-1:0]     rdy,
  output logic [SEL_W-1:0]                     sel,
  output logic                                 haz
);
  // Scan oldest to youngest so the youngest matching producer overwrites older results.
  always_comb begin
    sel = '0;
    haz = 1'b0;
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      if (prod[i] && waddr[i] == rd_addr) begin
        if (SEL_W'(i) >= rdy[i]) begin
          sel = SEL_W'(i + 1);
          haz = 1'b0;
        end else begin
          sel = '0;
          haz = 1'b1;
        end
      end
    end
    if (!rd_en || rd_addr == '0) begin
      sel = '0;
      haz = 1'b0;
    end
  end
endmodule

module parc_bypass_scoreboard #(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 5,
  parameter int SEL_W        = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_val,
  input  logic                            issue_wen,
  input  logic [REG_AW-1:0]               issue_waddr,
  input  logic [SEL_W-1:0]                issue_rdy_stg,
  input  logic [NUM_STAGES-1:0]           stall_in,
  input  logic                            squash_in,
  input  logic [NUM_RD_PORTS-1:0]         rd_en,
  input  logic [NUM_RD_PORTS*REG_AW-1:0]  rd_addr,
  output logic [NUM_RD_PORTS*SEL_W-1:0]   byp_sel,
  output logic                            hazard_stall,
  output logic [NUM_STAGES-1:0]           stage_val,
  output logic                            retire_val,
  output logic [REG_AW-1:0]               retire_waddr
);
  localparam int LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0]              vld_pipe, vld_d;
  logic [NUM_STAGES-1:0]              wen_q, wen_d;
  logic [NUM_STAGES-1:0][REG_AW-1:0]  waddr_q, waddr_d;
  logic [NUM_STAGES-1:0][SEL_W-1:0]   rdy_q, rdy_d;
  logic [NUM_STAGES-1:0]              prod;
  logic [NUM_RD_PORTS-1:0]            port_haz;
  logic                               load0;

  assign load0 = issue_val && !squash_in && !hazard_stall;

  // A held stage keeps its entry; a stage behind a stalled one but itself free takes a bubble.
  always_comb begin
    vld_d   = vld_pipe;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    rdy_d   = rdy_q;
    if (!stall_in[0]) begin
      vld_d[0]   = load0;
      wen_d[0]   = issue_wen;
      waddr_d[0] = issue_waddr;
      rdy_d[0]   = issue_rdy_stg;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (!stall_in[i-1]) begin
        vld_d[i]   = vld_pipe[i-1];
        wen_d[i]   = wen_q[i-1];
        waddr_d[i] = waddr_q[i-1];
        rdy_d[i]   = rdy_q[i-1];
      end else if (!stall_in[i]) begin
        vld_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      wen_q    <= '0;
      waddr_q  <= '0;
      rdy_q    <= '0;
    end else begin
      vld_pipe <= vld_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      rdy_q    <= rdy_d;
    end
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      prod[i] = vld_pipe[i] && wen_q[i] && (waddr_q[i] != '0);
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    parc_byp_lookup #(
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW),
      .SEL_W      (SEL_W)
    ) u_lookup (
      .rd_en   (rd_en[p]),
      .rd_addr (rd_addr[p*REG_AW +: REG_AW]),
      .prod    (prod),
      .waddr   (waddr_q),
      .rdy     (rdy_q),
      .sel     (byp_sel[p*SEL_W +: SEL_W]),
      .haz     (port_haz[p])
    );
  end

  assign hazard_stall = |port_haz;
  assign stage_val    = vld_pipe & wen_q;
  assign retire_val   = prod[LAST] && !stall_in[LAST];
  assign retire_waddr = retire_val ? waddr_q[LAST] : '0;
endmodule

// File: tb/tb_parc_bypass_scoreboard.sv
// Directed scenarios plus a random stream, all checked each cycle against an entry-list model.
module tb_parc_bypass_scoreboard;
  localparam int NS = 5;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int SW = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               issue_val, issue_wen, squash_in;
  logic [AW-1:0]      issue_waddr;
  logic [SW-1:0]      issue_rdy_stg;
  logic [NS-1:0]      stall_in;
  logic [NR-1:0]      rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*SW-1:0]   byp_sel;
  logic               hazard_stall, retire_val;
  logic [NS-1:0]      stage_val;
  logic [AW-1:0]      retire_waddr;

  int checks = 0;
  int errors = 0;

  parc_bypass_scoreboard #(.NUM_STAGES(NS), .NUM_RD_PORTS(NR), .REG_AW(AW), .SEL_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_val     (issue_val),
    .issue_wen     (issue_wen),
    .issue_waddr   (issue_waddr),
    .issue_rdy_stg (issue_rdy_stg),
    .stall_in      (stall_in),
    .squash_in     (squash_in),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .byp_sel       (byp_sel),
    .hazard_stall  (hazard_stall),
    .stage_val     (stage_val),
    .retire_val    (retire_val),
    .retire_waddr  (retire_waddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset)
      assert ((stall_in & (stall_in + 1'b1)) == '0) else $error("stall_in not monotone %b", stall_in);

  // Reference: list of in-flight instructions, index = stage.
  typedef struct {
    bit     val;
    bit     wen;
    int     wa;
    int     rdy;
  } ent_t;
  ent_t m [NS];
  int   exp_sel [NR];
  bit   exp_haz;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) m[i] = '{0, 0, 0, 0};
  endfunction

  function automatic void model_lookup();
    exp_haz = 0;
    for (int p = 0; p < NR; p++) begin
      int  a;
      bit  found;
      a = int'(rd_addr[p*AW +: AW]);
      exp_sel[p] = 0;
      found = 0;
      if (rd_en[p] && a != 0)
        for (int i = 0; i < NS; i++)
          if (!found && m[i].val && m[i].wen && m[i].wa == a) begin
            found = 1;
            if (i >= m[i].rdy) exp_sel[p] = i + 1;
            else exp_haz = 1;
          end
    end
  endfunction

  task automatic check_all();
    int sv;
    bit rv;
    model_lookup();
    sv = 0;
    for (int i = 0; i < NS; i++) if (m[i].val && m[i].wen) sv |= (1 << i);
    rv = m[NS-1].val && m[NS-1].wen && m[NS-1].wa != 0 && !stall_in[NS-1];
    for (int p = 0; p < NR; p++) chk($sformatf("byp_sel%0d", p), 32'(byp_sel[p*SW +: SW]), exp_sel[p]);
    chk("hazard_stall", 32'(hazard_stall), 32'(exp_haz));
    chk("stage_val", 32'(stage_val), sv);
    chk("retire_val", 32'(retire_val), 32'(rv));
    chk("retire_waddr", 32'(retire_waddr), rv ? m[NS-1].wa : 0);
  endtask

  // Advance the model by one edge using the inputs and state seen just before it.
  function automatic void model_step();
    ent_t nx [NS];
    model_lookup();
    for (int i = 0; i < NS; i++) nx[i] = m[i];
    for (int i = NS-1; i >= 1; i--) begin
      if (!stall_in[i-1]) nx[i] = m[i-1];
      else if (!stall_in[i]) nx[i].val = 0;
    end
    if (!stall_in[0]) begin
      if (issue_val && !squash_in && !exp_haz)
        nx[0] = '{1, issue_wen, int'(issue_waddr), int'(issue_rdy_stg)};
      else
        nx[0].val = 0;
    end
    for (int i = 0; i < NS; i++) m[i] = nx[i];
  endfunction

  task automatic drive(bit iv, bit wen, int wa, int rdy, int st, bit sq,
                       int en, int a0, int a1, int a2);
    issue_val     = iv;
    issue_wen     = wen;
    issue_waddr   = AW'(wa);
    issue_rdy_stg = SW'(rdy);
    stall_in      = NS'(st);
    squash_in     = sq;
    rd_en         = NR'(en);
    rd_addr       = {AW'(a2), AW'(a1), AW'(a0)};
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else model_step();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
  endtask

  task automatic issue(int wa, int rdy);
    drive(1, 1, wa, rdy, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  int alu_want [6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    model_clear();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 3'b111, 1, 2, 3);
    chk("reset_haz", 32'(hazard_stall), 0);
    tick();
    reset = 1'b0;

    // ALU chain
    issue(3, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 3'b001, 3, 0, 0);
      chk("alu_sel", 32'(byp_sel[SW-1:0]), alu_want[k]);
      tick();
    end

    // Load-use
    issue(5, 1);
    drive(1, 1, 6, 0, 0, 0, 3'b010, 0, 5, 0);
    chk("lu_haz", 32'(hazard_stall), 1);
    tick();
    drive(1, 1, 6, 0, 0, 0, 3'b010, 0, 5, 0);
    chk("lu_sel", 32'(byp_sel[SW +: SW]), 2);
    chk("lu_bubble", 32'(stage_val[0]), 0);
    tick();

    // Double write, youngest wins; r0 never produces
    idle(NS + 1);
    issue(4, 0);
    issue(4, 0);
    drive(1, 1, 0, 0, 0, 0, 3'b100, 0, 0, 4);
    chk("dbl_sel", 32'(byp_sel[2*SW +: SW]), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    chk("r0_sel", 32'(byp_sel[SW-1:0]), 0);
    tick();

    // Stall shape
    idle(NS + 1);
    issue(7, 0); issue(8, 0); issue(9, 0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 5'b00011, 0, 3'b011, 7, 9, 0);
      chk("stl_hold", 32'(byp_sel[SW +: SW]), 1);
      if (k == 1) chk("stl_bubble", 32'(stage_val[2]), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 3'b011, 7, 9, 0);
    chk("stl_r7", 32'(byp_sel[SW-1:0]), 5);
    tick();

    // Squash and issue-under-stall
    idle(NS + 1);
    drive(1, 1, 10, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 11, 0, 0, 0, 0, 0, 0, 0);
    chk("sq_empty", 32'(stage_val[0]), 0);
    tick();
    drive(1, 1, 12, 0, 5'b00001, 0, 3'b011, 11, 12, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3'b011, 11, 12, 0);
    chk("stl_ign12", 32'(byp_sel[SW +: SW]), 0);
    chk("stl_keep11", 32'(byp_sel[SW-1:0]), 1);
    tick();

    // Async reset with three pending writers
    idle(NS + 1);
    issue(1, 4); issue(2, 4); issue(3, 4);
    drive(0, 0, 0, 0, 0, 0, 3'b111, 1, 2, 3);
    chk("pre_rst_haz", 32'(hazard_stall), 1);
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    chk("rst_sel", 32'(byp_sel), 0);
    tick();
    reset = 1'b0;

    // Random stream
    for (int n = 0; n < 3000; n++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? ((1 << $urandom_range(1, NS)) - 1) : 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
            $urandom_range(0, NS), st, $urandom_range(0, 9) == 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
